// File: rtl/piezo_seq_drv.sv
// Piezo alarm sequencer: arbitrates ovr/batt/moving requests
// and plays a note/gap cadence as a differential square wave.
module piezo_seq_drv #(
  parameter int DIV_W         = 16,
  parameter int DUR_W         = 24,
  parameter int TONE_HI_HALF  = 12500,
  parameter int TONE_MID_HALF = 16667,
  parameter int TONE_LO_HALF  = 25000,
  parameter int BEEP_ON       = 2500000,
  parameter int BEEP_OFF      = 2500000,
  parameter int CHIRP_GAP     = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ovr_spd,
  input  logic       batt_low,
  input  logic       moving,
  output logic       audio_o,
  output logic       audio_o_n,
  output logic       busy,
  output logic [1:0] mode_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] M_NONE = 2'd0;
  localparam logic [1:0] M_MOVE = 2'd1;
  localparam logic [1:0] M_BATT = 2'd2;
  localparam logic [1:0] M_OVR  = 2'd3;

  localparam logic [DIV_W-1:0] HI_LAST =
    DIV_W'(TONE_HI_HALF - 1);
  localparam logic [DIV_W-1:0] MID_LAST =
    DIV_W'(TONE_MID_HALF - 1);
  localparam logic [DIV_W-1:0] LO_LAST =
    DIV_W'(TONE_LO_HALF - 1);

  localparam logic [DUR_W-1:0] ON_LAST =
    DUR_W'(BEEP_ON - 1);
  localparam logic [DUR_W-1:0] OVR_GAP_LAST =
    DUR_W'(BEEP_OFF - 1);
  localparam logic [DUR_W-1:0] BATT_GAP_LAST =
    DUR_W'(2 * BEEP_OFF - 1);
  localparam logic [DUR_W-1:0] MOVE_GAP_LAST =
    DUR_W'(CHIRP_GAP - 1);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] dur_d;
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] half_d;
  logic             aud_q;
  logic             aud_d;
  logic             aud_n_q;
  logic             aud_n_d;
  logic             busy_q;
  logic             busy_d;
  logic             drop_q;
  logic             drop_d;

  logic [1:0]       top_req;
  logic             own_req;
  logic [DIV_W-1:0] half_last;
  logic [DUR_W-1:0] gap_last;
  logic             start;
  logic             finish;

  // Highest asserted request by fixed priority.
  always_comb begin
    top_req = M_NONE;
    priority case (1'b1)
      ovr_spd:  top_req = M_OVR;
      batt_low: top_req = M_BATT;
      moving:   top_req = M_MOVE;
      default:  top_req = M_NONE;
    endcase
  end

  // Request, tone and gap length belonging to the active pattern.
  always_comb begin
    own_req   = 1'b0;
    half_last = HI_LAST;
    gap_last  = OVR_GAP_LAST;
    unique case (mode_q)
      M_OVR: begin
        own_req   = ovr_spd;
        half_last = HI_LAST;
        gap_last  = OVR_GAP_LAST;
      end
      M_BATT: begin
        own_req  = batt_low;
        gap_last = BATT_GAP_LAST;
        unique case (idx_q)
          2'd0:    half_last = HI_LAST;
          2'd1:    half_last = MID_LAST;
          default: half_last = LO_LAST;
        endcase
      end
      M_MOVE: begin
        own_req   = moving;
        half_last = LO_LAST;
        gap_last  = MOVE_GAP_LAST;
      end
      default: begin
        own_req   = 1'b0;
        half_last = HI_LAST;
        gap_last  = OVR_GAP_LAST;
      end
    endcase
  end

  // Sequencer next state: arbitration, cadence, tone divider.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    half_d  = half_q;
    aud_d   = aud_q;
    drop_d  = drop_q;
    start   = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (top_req != M_NONE) start = 1'b1;
      end
      NOTE: begin
        if (top_req > mode_q) begin
          start = 1'b1;
        end else if (dur_q == ON_LAST) begin
          if (drop_q || !own_req) begin
            finish = 1'b1;
          end else if (mode_q == M_BATT &&
                       idx_q != 2'd2) begin
            idx_d  = idx_q + 2'd1;
            dur_d  = '0;
            half_d = '0;
            aud_d  = 1'b1;
          end else begin
            state_d = GAP;
            dur_d   = '0;
            half_d  = '0;
            aud_d   = 1'b0;
          end
        end else begin
          dur_d  = dur_q + DUR_W'(1);
          drop_d = drop_q | ~own_req;
          if (half_q == half_last) begin
            half_d = '0;
            aud_d  = ~aud_q;
          end else begin
            half_d = half_q + DIV_W'(1);
          end
        end
      end
      GAP: begin
        if (top_req > mode_q || !own_req) begin
          finish = 1'b1;
        end else if (dur_q == gap_last) begin
          state_d = NOTE;
          idx_d   = '0;
          dur_d   = '0;
          half_d  = '0;
          aud_d   = 1'b1;
          drop_d  = 1'b0;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      if (top_req != M_NONE) begin
        start = 1'b1;
      end else begin
        state_d = IDLE;
        mode_d  = M_NONE;
        idx_d   = '0;
        dur_d   = '0;
        half_d  = '0;
        aud_d   = 1'b0;
        drop_d  = 1'b0;
      end
    end

    if (start) begin
      state_d = NOTE;
      mode_d  = top_req;
      idx_d   = '0;
      dur_d   = '0;
      half_d  = '0;
      aud_d   = 1'b1;
      drop_d  = 1'b0;
    end
  end

  // Output leg values: differential only while a note sounds.
  always_comb begin
    busy_d  = (state_d != IDLE);
    aud_n_d = (state_d == NOTE) ? ~aud_d : 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= M_NONE;
      idx_q   <= '0;
      dur_q   <= '0;
      half_q  <= '0;
      aud_q   <= 1'b0;
      aud_n_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      aud_q   <= aud_d;
      aud_n_q <= aud_n_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign audio_o   = aud_q;
  assign audio_o_n = aud_n_q;
  assign busy      = busy_q;
  assign mode_o    = mode_q;

endmodule

// File: tb/tb_piezo_seq_drv.sv
// Bench for piezo_seq_drv: directed scenarios plus random
// request traffic checked against a cadence-level model.
module tb_piezo_seq_drv;

  localparam int HI   = 2;
  localparam int MID  = 3;
  localparam int LO   = 4;
  localparam int ON   = 24;
  localparam int OFF  = 12;
  localparam int CG   = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ovr_spd = 1'b0;
  logic       batt_low = 1'b0;
  logic       moving = 1'b0;
  logic       audio_o;
  logic       audio_o_n;
  logic       busy;
  logic [1:0] mode_o;

  int n_chk  = 0;
  int n_fail = 0;

  // model: phase 0 idle, 1 note, 2 gap
  int m_ph   = 0;
  int m_mode = 0;
  int m_idx  = 0;
  int m_t    = 0;
  bit m_drop = 1'b0;

  always #5 clk = ~clk;

  piezo_seq_drv #(
    .DIV_W(16),
    .DUR_W(24),
    .TONE_HI_HALF(HI),
    .TONE_MID_HALF(MID),
    .TONE_LO_HALF(LO),
    .BEEP_ON(ON),
    .BEEP_OFF(OFF),
    .CHIRP_GAP(CG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ovr_spd(ovr_spd),
    .batt_low(batt_low),
    .moving(moving),
    .audio_o(audio_o),
    .audio_o_n(audio_o_n),
    .busy(busy),
    .mode_o(mode_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int note_half(int md, int ix);
    if (md == 3) return HI;
    if (md == 1) return LO;
    if (ix == 0) return HI;
    if (ix == 1) return MID;
    return LO;
  endfunction

  function automatic int gap_len(int md);
    if (md == 3) return OFF;
    if (md == 2) return 2 * OFF;
    return CG;
  endfunction

  task automatic m_start(input int md);
    m_ph   = 1;
    m_mode = md;
    m_idx  = 0;
    m_t    = 0;
    m_drop = 1'b0;
  endtask

  task automatic m_rearb(input int top);
    if (top != 0) begin
      m_start(top);
    end else begin
      m_ph   = 0;
      m_mode = 0;
      m_idx  = 0;
      m_t    = 0;
      m_drop = 1'b0;
    end
  endtask

  task automatic model_step();
    int top;
    bit own;
    top = ovr_spd ? 3 : batt_low ? 2 : moving ? 1 : 0;
    own = (m_mode == 3) ? ovr_spd :
          (m_mode == 2) ? batt_low :
          (m_mode == 1) ? moving : 1'b0;
    if (rst) begin
      m_rearb(0);
    end else if (m_ph == 0) begin
      if (top != 0) m_start(top);
    end else if (m_ph == 1) begin
      if (top > m_mode) begin
        m_start(top);
      end else if (m_t == ON - 1) begin
        if (m_drop || !own) m_rearb(top);
        else if (m_mode == 2 && m_idx < 2) begin
          m_idx++;
          m_t = 0;
        end else begin
          m_ph = 2;
          m_t  = 0;
        end
      end else begin
        m_t++;
        if (!own) m_drop = 1'b1;
      end
    end else begin
      if (top > m_mode || !own) m_rearb(top);
      else if (m_t == gap_len(m_mode) - 1)
        m_start(m_mode);
      else m_t++;
    end
  endtask

  task automatic compare_all();
    bit ea;
    ea = 1'b0;
    if (m_ph == 1)
      ea = ((m_t / note_half(m_mode, m_idx)) % 2) == 0;
    check("audio_o", 32'(audio_o), 32'(ea));
    check("audio_o_n", 32'(audio_o_n),
          32'((m_ph == 1) ? !ea : 1'b0));
    check("busy", 32'(busy), 32'(m_ph != 0));
    check("mode_o", 32'(mode_o),
          32'((m_ph == 0) ? 0 : m_mode));
  endtask

  task automatic cyc(input bit r, input bit o,
                     input bit b, input bit m);
    @(negedge clk);
    rst      = r;
    ovr_spd  = o;
    batt_low = b;
    moving   = m;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    bit o;
    bit b;
    bit m;
    bit r;
    int len;

    // reset and idle
    repeat (3) cyc(1, 0, 0, 0);
    repeat (200) cyc(0, 0, 0, 0);
    check("idle_busy", 32'(busy), 32'd0);

    // OVR cadence
    cyc(0, 1, 0, 0);
    check("ovr_first_aud", 32'(audio_o), 32'd1);
    check("ovr_first_mode", 32'(mode_o), 32'd3);
    repeat (99) cyc(0, 1, 0, 0);
    repeat (60) cyc(0, 0, 0, 0);

    // BATT sequence
    repeat (220) cyc(0, 0, 1, 0);
    repeat (60) cyc(0, 0, 0, 0);

    // moving preempted by ovr 10 cycles into note
    repeat (11) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    check("preempt_mode", 32'(mode_o), 32'd3);
    check("preempt_aud", 32'(audio_o), 32'd1);
    repeat (40) cyc(0, 1, 0, 1);
    repeat (100) cyc(0, 0, 0, 1);
    repeat (80) cyc(0, 0, 0, 0);

    // BATT drop 5 cycles into MID
    repeat (29) cyc(0, 0, 1, 0);
    repeat (18) cyc(0, 0, 0, 0);
    check("mid_still_on", 32'(mode_o), 32'd2);
    repeat (2) cyc(0, 0, 0, 0);
    check("mid_done_busy", 32'(busy), 32'd0);
    repeat (10) cyc(0, 0, 0, 0);

    // BATT drop 5 cycles into gap
    repeat (77) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("gap_drop_busy", 32'(busy), 32'd0);
    repeat (10) cyc(0, 0, 0, 0);

    // ovr drops in its gap, moving takes over
    repeat (27) cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    check("fallback_mode", 32'(mode_o), 32'd1);
    check("fallback_aud", 32'(audio_o), 32'd1);
    repeat (6) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("rst_aud", 32'(audio_o), 32'd0);
    check("rst_mode", 32'(mode_o), 32'd0);
    repeat (20) cyc(0, 0, 0, 0);

    // random request traffic
    repeat (70) begin
      o   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 2) == 0);
      m   = ($urandom_range(0, 1) == 0);
      r   = ($urandom_range(0, 40) == 0);
      len = $urandom_range(1, 90);
      for (int i = 0; i < len; i++)
        cyc(r && (i == 0), o, b, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
